hram_ctrl: RTL

HRAM_CTRL -- requirements
Module: hram_ctrl

---
 rtl/hram_pkg.sv | 20 ++
 rtl/hram_storage.sv | 28 ++
 rtl/hram_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/hram_pkg.sv
// Shared constants, state type and sizing helper for the high-RAM controller.
package hram_pkg;

  localparam logic [7:0] DEF_BASE = 8'h80;
  localparam logic [7:0] DEF_TOP  = 8'hFE;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Smallest address width able to index depth words (at least one bit).
  function automatic int idx_width(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/hram_storage.sv
// Single-port word array: one synchronous write port and one registered read port.
module hram_storage #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 127,
  parameter int IDX_W  = 7
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read register holds its value between reads; only it is reset, never the array.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)  rdata <= '0;
    else if (re)   rdata <= mem[addr];
  end

endmodule

// File: rtl/hram_ctrl.sv
// High-RAM controller: FFxx address decode, bus arbitration and post-reset clear sweep.
module hram_ctrl
  import hram_pkg::*;
#(
  parameter int         DATA_W         = 8,
  parameter logic [7:0] BASE           = DEF_BASE,
  parameter logic [7:0] TOP            = DEF_TOP,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              soc_rd,
  input  logic              soc_wr,
  input  logic              ffxx,
  input  logic [7:0]        a,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  output logic              d_oe,
  output logic              busy
);

  localparam int               DEPTH     = int'(TOP) - int'(BASE) + 1;
  localparam int               IDX_W     = idx_width(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam state_t           RST_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  cnt;
  logic              hit;
  logic [IDX_W-1:0]  idx;
  logic              bus_wr, bus_rd;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // FFFF is the interrupt-enable register and must never be claimed here.
  assign hit    = ffxx && (a != 8'hFF) && (a >= BASE) && (a <= TOP);
  assign idx    = IDX_W'(a - BASE);
  assign bus_wr = hit && soc_wr && !busy;
  assign bus_rd = hit && soc_rd && !soc_wr && !busy;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= RST_STATE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && cnt == LAST_IDX) state_nxt = IDLE;
  end

  // Clear engine owns the write port while busy; bus traffic is dropped.
  always_comb begin
    busy      = (state == CLEAR);
    mem_we    = bus_wr;
    mem_addr  = idx;
    mem_wdata = d_in;
    if (busy) begin
      mem_we    = 1'b1;
      mem_addr  = cnt;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt  <= '0;
      d_oe <= 1'b0;
    end else begin
      d_oe <= bus_rd;
      if (state == CLEAR) cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
    end
  end

  hram_storage #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_storage (
    .clk     (clk),
    .n_reset (n_reset),
    .we      (mem_we),
    .re      (bus_rd),
    .addr    (mem_addr),
    .wdata   (mem_wdata),
    .rdata   (d_out)
  );

endmodule
